// File: rtl/csdiv_if.sv
// Handshake bundle for the iterative divider.
//   master: operand source / result consumer (drives in_valid, dividend,
//           divisor, out_ready)
//   slave : divider (drives in_ready, out_valid, quotient, remainder,
//           div_by_zero)
interface csdiv_if #(
  parameter int bitsize = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [bitsize-1:0] dividend;
  logic [bitsize-1:0] divisor;
  logic               out_valid;
  logic               out_ready;
  logic [bitsize-1:0] quotient;
  logic [bitsize-1:0] remainder;
  logic               div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/csdiv_iterative.sv
// Sequential restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : csdiv_if.slave -- in_valid/in_ready + dividend/divisor in,
//           out_valid/out_ready + quotient/remainder/div_by_zero out
// Divide by zero: quotient all ones, remainder = dividend, div_by_zero set.
// Optional macro CSDIV_SIGNED_EN: two's complement operands/results
// (truncating quotient, remainder signed like the dividend).
module csdiv_iterative #(
  parameter int bitsize = 8
) (
  input  logic    clk,
  input  logic    rst_n,
  csdiv_if.slave  bus
);
  localparam int CW = $clog2(bitsize + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [bitsize-1:0] dvd_sh, dvs, prem, quo;
  logic [bitsize-1:0] q_out, r_out;
  logic               dz;
  logic               in_ready, out_valid;

  logic [bitsize:0]   trial, diff;
  logic               ge, last;
  logic [bitsize-1:0] prem_nxt, quo_nxt;
  logic [bitsize-1:0] a_mag, b_mag, q_fin, r_fin;

`ifdef CSDIV_SIGNED_EN
  logic neg_q, neg_r;
  // Magnitudes only; the most-negative value maps onto itself, which is
  // the correct unsigned magnitude.
  assign a_mag = bus.dividend[bitsize-1] ? -bus.dividend : bus.dividend;
  assign b_mag = bus.divisor[bitsize-1]  ? -bus.divisor  : bus.divisor;
  assign q_fin = neg_q ? -quo_nxt  : quo_nxt;
  assign r_fin = neg_r ? -prem_nxt : prem_nxt;
`else
  assign a_mag = bus.dividend;
  assign b_mag = bus.divisor;
  assign q_fin = quo_nxt;
  assign r_fin = prem_nxt;
`endif

  // One restoring step: trial is one bit wider so the compare cannot wrap.
  always_comb begin
    trial    = {prem, dvd_sh[bitsize-1]};
    diff     = trial - {1'b0, dvs};
    ge       = (trial >= {1'b0, dvs});
    prem_nxt = ge ? diff[bitsize-1:0] : trial[bitsize-1:0];
    quo_nxt  = {quo[bitsize-2:0], ge};
    last     = (cnt == CW'(bitsize - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) state_nxt = (bus.divisor == '0) ? DONE : CALC;
      end
      CALC: if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      dvd_sh <= '0;
      dvs    <= '0;
      prem   <= '0;
      quo    <= '0;
      q_out  <= '0;
      r_out  <= '0;
      dz     <= 1'b0;
`ifdef CSDIV_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (bus.in_valid) begin
          dvd_sh <= a_mag;
          dvs    <= b_mag;
          prem   <= '0;
          quo    <= '0;
          cnt    <= '0;
`ifdef CSDIV_SIGNED_EN
          neg_q  <= bus.dividend[bitsize-1] ^ bus.divisor[bitsize-1];
          neg_r  <= bus.dividend[bitsize-1];
`endif
          // Zero divisor skips the core; result is known at accept.
          if (bus.divisor == '0) begin
            q_out <= '1;
            r_out <= bus.dividend;
            dz    <= 1'b1;
          end else begin
            dz    <= 1'b0;
          end
        end
        CALC: begin
          dvd_sh <= dvd_sh << 1;
          prem   <= prem_nxt;
          quo    <= quo_nxt;
          cnt    <= cnt + CW'(1);
          if (last) begin
            q_out <= q_fin;
            r_out <= r_fin;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.out_valid   = out_valid;
  assign bus.quotient    = q_out;
  assign bus.remainder   = r_out;
  assign bus.div_by_zero = dz;
endmodule

// File: tb/tb_csdiv_iterative.sv
// Bench for csdiv_iterative: directed steps then randomized operations,
// each checked against an arithmetic reference model.
module tb_csdiv_iterative;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_bad = 0;

  csdiv_if #(.bitsize(W)) bus();
  csdiv_iterative #(.bitsize(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
    z = 1'b0;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1;
    end else begin
`ifdef CSDIV_SIGNED_EN
      int sa, sb;
      sa = $signed(a);
      sb = $signed(b);
      if (sa == -(2 ** (W - 1)) && sb == -1) begin
        q = a; r = '0;
      end else begin
        q = W'(sa / sb);
        r = W'(sa % sb);
      end
`else
      q = a / b;
      r = a % b;
`endif
    end
  endfunction

  // Counts cycles (negedges) after the accept edge until out_valid.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.out_valid && lat < 200);
    if (lat >= 200) chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  task automatic check_res(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int lat);
    logic [W-1:0] q, r;
    logic z;
    ref_div(a, b, q, r, z);
    chk({tag, "_lat"}, 32'(lat), (b == '0) ? 32'd1 : 32'(W + 1));
    chk({tag, "_q"},   32'(bus.quotient), 32'(q));
    chk({tag, "_r"},   32'(bus.remainder), 32'(r));
    chk({tag, "_dz"},  32'(bus.div_by_zero), 32'(z));
  endtask

  // Called at a negedge with the divider idle.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    int lat;
    logic [W-1:0] q0, r0;
    bus.out_ready = (hold == 0);
    bus.in_valid  = 1'b1;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
    bus.dividend  = W'($urandom);
    bus.divisor   = W'($urandom);
    wait_out(lat);
    check_res(tag, a, b, lat);
    q0 = bus.quotient;
    r0 = bus.remainder;
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.dividend = W'($urandom);
      bus.divisor  = W'($urandom);
      @(negedge clk);
      chk({tag, "_hold_v"},  32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_ir"}, 32'(bus.in_ready),  32'd0);
      chk({tag, "_hold_q"},  32'(bus.quotient),  32'(q0));
      chk({tag, "_hold_r"},  32'(bus.remainder), 32'(r0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_post_ir"}, 32'(bus.in_ready),  32'd1);
    chk({tag, "_post_ov"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] a, b;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ir", 32'(bus.in_ready),    32'd1);
    chk("rst_ov", 32'(bus.out_valid),   32'd0);
    chk("rst_q",  32'(bus.quotient),    32'd0);
    chk("rst_r",  32'(bus.remainder),   32'd0);
    chk("rst_dz", 32'(bus.div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("d100_7", 8'd100, 8'd7, 0);
    run_op("dz5", 8'h05, 8'h00, 0);

    // in_valid held high across two back-to-back operations
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.dividend  = 8'hFF;
    bus.divisor   = 8'h01;
    @(posedge clk);
    #1;
    wait_out(lat);
    check_res("ff_01", 8'hFF, 8'h01, lat);
    bus.dividend = 8'h03;
    bus.divisor  = 8'hFF;
    @(negedge clk);
    chk("held_ir", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_out(lat);
    check_res("03_ff", 8'h03, 8'hFF, lat);
    @(negedge clk);

    run_op("d200_9_hold", 8'd200, 8'd9, 5);

    // Reset pulse during the 4th CALC cycle aborts the operation.
    bus.in_valid = 1'b1;
    bus.dividend = 8'd77;
    bus.divisor  = 8'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ov", 32'(bus.out_valid),   32'd0);
    chk("abort_ir", 32'(bus.in_ready),    32'd1);
    chk("abort_q",  32'(bus.quotient),    32'd0);
    chk("abort_r",  32'(bus.remainder),   32'd0);
    chk("abort_dz", 32'(bus.div_by_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("d50_5", 8'd50, 8'd5, 0);

`ifdef CSDIV_SIGNED_EN
    run_op("s_m100_7", 8'h9C, 8'h07, 0);
    chk("s_m100_7_qc", 32'(bus.quotient), 32'h000000F2);
    run_op("s_100_m7", 8'd100, 8'hF9, 0);
    run_op("s_m128_m1", 8'h80, 8'hFF, 0);
    run_op("s_m128_1", 8'h80, 8'h01, 1);
    run_op("s_m7_0", 8'hF9, 8'h00, 0);
`endif

    for (int i = 0; i < 40; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      if (i < 4) b = W'(i + 1);
      run_op("rnd", a, b, int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
